// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider sharing one {hi, lo} accumulator pair.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic [1:0]       r_state, w_state_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic             r_neg, w_neg_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;

    logic             w_signed_a, w_signed_b, w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic             w_b_zero, w_ovf, w_entry_neg;
    logic [WIDTH-1:0] w_special;
    logic [WIDTH:0]   w_sum, w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff, w_hi_step, w_lo_step;
    logic [PW-1:0]    w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo_s, w_rem_s, w_final;

    // Operand decode, magnitudes and early-out detection on entry
    always_comb begin
        w_signed_a  = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
        w_signed_b  = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
        w_sa        = w_signed_a & operand_a[WIDTH-1];
        w_sb        = w_signed_b & operand_b[WIDTH-1];
        w_mag_a     = w_sa ? (~operand_a + WIDTH'(1)) : operand_a;
        w_mag_b     = w_sb ? (~operand_b + WIDTH'(1)) : operand_b;
        w_b_zero    = (operand_b == '0);
        w_ovf       = op[2] & ~op[0] & (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                      & (operand_b == '1);
        w_special   = w_b_zero ? (op[1] ? operand_a : '1)
                                : (op[1] ? '0 : operand_a);
        // Remainder follows the dividend; MUL low half needs no correction
        if (op[2] & op[1])
            w_entry_neg = w_sa;
        else if (op == OP_MUL)
            w_entry_neg = 1'b0;
        else
            w_entry_neg = w_sa ^ w_sb;
    end

    // One iteration of the shared datapath plus final sign correction
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_b});
        w_diff    = w_rem_sh[WIDTH-1:0] - r_b;
        w_hi_step = r_op[2] ? (w_ge ? w_diff : w_rem_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
        w_lo_step = r_op[2] ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
        w_prod    = {w_hi_step, w_lo_step};
        w_prod_s  = r_neg ? (~w_prod + PW'(1)) : w_prod;
        w_quo_s   = r_neg ? (~w_lo_step + WIDTH'(1)) : w_lo_step;
        w_rem_s   = r_neg ? (~w_hi_step + WIDTH'(1)) : w_hi_step;
        case (r_op)
            OP_MUL:                      w_final = w_prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_s[PW-1:WIDTH];
            OP_DIV, OP_DIVU:             w_final = w_quo_s;
            default:                     w_final = w_rem_s;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_neg_nxt    = r_neg;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_b_nxt      = r_b;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_op_nxt  = op;
                        w_neg_nxt = w_entry_neg;
                        if (op[2] & (w_b_zero | w_ovf)) begin
                            w_result_nxt = w_special;
                            w_done_nxt   = 1'b1;
                            w_state_nxt  = S_FINISH;
                        end else begin
                            w_hi_nxt    = '0;
                            w_lo_nxt    = w_mag_a;
                            w_b_nxt     = w_mag_b;
                            w_cnt_nxt   = CW'(WIDTH);
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    w_hi_nxt  = w_hi_step;
                    w_lo_nxt  = w_lo_step;
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        w_result_nxt = w_final;
                        w_done_nxt   = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_state_nxt  = S_FINISH;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_neg    <= w_neg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_b      <= w_b_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign zero_flag = (r_result == '0);

endmodule
